// File: rtl/axi_lite_sram_slave_pkg.sv
// axi_pkg: AXI-Lite response codes and write/read FSM state types shared by the SRAM slave
package axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
endpackage

// File: rtl/axi_lite_sram_slave_if.sv
// axi_lite_sram_slave_if: AXI4-Lite AW/W/B/AR/R channel bundle; master drives requests, slave drives READYs and responses
interface axi_lite_sram_slave_if #(parameter int DWIDTH = 32, parameter int AWIDTH = 64);
  logic              AWVALID, AWREADY;
  logic [AWIDTH-1:0] AWADDR;
  logic              WVALID, WREADY;
  logic [DWIDTH-1:0] WDATA;
  logic [DWIDTH/8-1:0] WSTRB;
  logic              BVALID, BREADY;
  logic [1:0]        BRESP;
  logic              ARVALID, ARREADY;
  logic [AWIDTH-1:0] ARADDR;
  logic              RVALID, RREADY;
  logic [DWIDTH-1:0] RDATA;
  logic [1:0]        RRESP;
  modport master(output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
                 input AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP);
  modport slave(input AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
                output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP);
endinterface

// File: rtl/axi_lite_sram_slave_mem.sv
// axi_lite_mem: DEPTH x DWIDTH RAM, byte-strobed synchronous write, 1-cycle synchronous read, no reset
//  i_clk clock; i_we/i_waddr/i_wdata/i_wstrb write port; i_re/i_raddr/o_rdata read port
module axi_lite_mem #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 256
)(
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DWIDTH-1:0]          i_wdata,
  input  logic [DWIDTH/8-1:0]        i_wstrb,
  input  logic                       i_re,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DWIDTH-1:0]          o_rdata
);
  logic [DWIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DWIDTH/8; i++)
      if (i_we && i_wstrb[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI4-Lite target serving single-beat reads/writes from an internal RAM, SLVERR out of range
//  ACLK clock; ARESET async active-high reset; s AXI-Lite slave channels
module axi_lite_sram_slave import axi_pkg::*; #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 64,
  parameter logic [AWIDTH-1:0] BASE = '0,
  parameter int DEPTH  = 256
)(
  input logic ACLK,
  input logic ARESET,
  axi_lite_sram_slave_if.slave s
);
  localparam int NB = DWIDTH/8;
  localparam int BW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [AWIDTH-1:0] SPAN = AWIDTH'(DEPTH*NB);
  function automatic logic in_range(input logic [AWIDTH-1:0] a);
    return a >= BASE && (a - BASE) < SPAN;
  endfunction
  function automatic logic [IW-1:0] word_idx(input logic [AWIDTH-1:0] a);
    return IW'((a - BASE) >> BW);
  endfunction
  wr_state_t r_wr_state, w_wr_next;
  rd_state_t r_rd_state, w_rd_next;
  logic r_aw_held, r_w_held, w_aw_held_n, w_w_held_n;
  logic r_awready, r_wready, r_arready, w_awready_n, w_wready_n, w_arready_n;
  logic [AWIDTH-1:0] r_awaddr, w_awaddr;
  logic [DWIDTH-1:0] r_wdata, w_wdata, w_mem_rdata;
  logic [NB-1:0]     r_wstrb, w_wstrb;
  logic [1:0]        r_bresp, r_rresp;
  logic              r_rd_ok;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_ar_ok;
  logic [IW-1:0] w_widx, w_ridx;
  assign w_aw_hs  = s.AWVALID & r_awready;
  assign w_w_hs   = s.WVALID & r_wready;
  assign w_ar_hs  = s.ARVALID & r_arready;
  // a channel completing on the commit edge supplies its payload directly from the bus
  assign w_awaddr = r_aw_held ? r_awaddr : s.AWADDR;
  assign w_wdata  = r_w_held ? r_wdata : s.WDATA;
  assign w_wstrb  = r_w_held ? r_wstrb : s.WSTRB;
  assign w_wr_ok  = in_range(w_awaddr);
  assign w_ar_ok  = in_range(s.ARADDR);
  assign w_widx   = word_idx(w_awaddr);
  assign w_ridx   = word_idx(s.ARADDR);
  always_comb begin
    w_wr_next   = r_wr_state;
    w_aw_held_n = r_aw_held | w_aw_hs;
    w_w_held_n  = r_w_held | w_w_hs;
    w_commit    = 1'b0;
    w_awready_n = 1'b0;
    w_wready_n  = 1'b0;
    if (r_wr_state == WR_IDLE) begin
      w_commit    = w_aw_held_n & w_w_held_n;
      w_wr_next   = w_commit ? WR_RESP : WR_IDLE;
      w_awready_n = !w_commit && !w_aw_held_n;
      w_wready_n  = !w_commit && !w_w_held_n;
    end else if (s.BREADY) begin
      w_wr_next   = WR_IDLE;
      w_aw_held_n = 1'b0;
      w_w_held_n  = 1'b0;
      w_awready_n = 1'b1;
      w_wready_n  = 1'b1;
    end
  end
  always_comb begin
    w_rd_next   = r_rd_state;
    w_arready_n = 1'b0;
    if (r_rd_state == RD_IDLE) begin
      w_rd_next   = w_ar_hs ? RD_DATA : RD_IDLE;
      w_arready_n = !w_ar_hs;
    end else begin
      w_rd_next   = s.RREADY ? RD_IDLE : RD_DATA;
      w_arready_n = s.RREADY;
    end
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_state <= WR_IDLE;
      r_rd_state <= RD_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_arready  <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
      r_rresp    <= RESP_OKAY;
      r_rd_ok    <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      r_rd_state <= w_rd_next;
      r_aw_held  <= w_aw_held_n;
      r_w_held   <= w_w_held_n;
      r_awready  <= w_awready_n;
      r_wready   <= w_wready_n;
      r_arready  <= w_arready_n;
      if (w_aw_hs) r_awaddr <= s.AWADDR;
      if (w_w_hs) begin
        r_wdata <= s.WDATA;
        r_wstrb <= s.WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_ar_hs) begin
        r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
        r_rd_ok <= w_ar_ok;
      end
    end
  end
  // RAM read data only changes on an AR handshake, so RDATA holds while RVALID waits
  axi_lite_mem #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_mem (
    .i_clk(ACLK), .i_we(w_commit & w_wr_ok), .i_waddr(w_widx), .i_wdata(w_wdata), .i_wstrb(w_wstrb),
    .i_re(w_ar_hs), .i_raddr(w_ridx), .o_rdata(w_mem_rdata)
  );
  assign s.AWREADY = r_awready;
  assign s.WREADY  = r_wready;
  assign s.ARREADY = r_arready;
  assign s.BVALID  = r_wr_state == WR_RESP;
  assign s.BRESP   = r_bresp;
  assign s.RVALID  = r_rd_state == RD_DATA;
  assign s.RRESP   = r_rresp;
  assign s.RDATA   = r_rd_ok ? w_mem_rdata : '0;
endmodule
